// File: rtl/catch_round_ctrl_if.sv
// Signal bundle between the catch round controller (master) and the ball SM / overlay (slave).
interface catch_round_ctrl_if;
  logic       vsync;
  logic       start;
  logic [1:0] ball_state;
  logic       catch_event;
  logic       throw_event;
  logic       serve;
  logic       serve_to;
  logic [2:0] round_state;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [7:0] rally;
  logic [7:0] best_rally;
  logic       drop_flag;
  logic       game_over;
  logic       winner;

  modport master (
    input  vsync, start, ball_state, catch_event, throw_event,
    output serve, serve_to, round_state, score1, score2, rally, best_rally,
           drop_flag, game_over, winner
  );

  modport slave (
    output vsync, start, ball_state, catch_event, throw_event,
    input  serve, serve_to, round_state, score1, score2, rally, best_rally,
           drop_flag, game_over, winner
  );
endinterface

// File: rtl/catch_round_ctrl.sv
// Round sequencer for the two-player catch game: serves, frame-timed holds/flights, scoring.
// Optional best-rally tracking is built only when CATCH_BEST_RALLY_EN is defined.
module catch_round_ctrl #(
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned HOLD_FRAMES   = 180,
  parameter int unsigned FLIGHT_FRAMES = 240,
  parameter int unsigned DROP_FRAMES   = 90
) (
  input logic                vclock,
  input logic                reset,
  catch_round_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StServe   = 3'd1,
    StHold    = 3'd2,
    StFlight  = 3'd3,
    StDropped = 3'd4,
    StOver    = 3'd5
  } state_e;

  localparam logic [7:0] HoldLast   = 8'(HOLD_FRAMES);
  localparam logic [7:0] FlightLast = 8'(FLIGHT_FRAMES);
  localparam logic [7:0] DropLast   = 8'(DROP_FRAMES);
  localparam logic [3:0] WinScore   = 4'(WIN_SCORE);

  state_e     state_q;
  logic       vsync_q;
  logic       start_q;
  logic       serve_q;
  logic       serve_to_q;
  logic [3:0] score1_q;
  logic [3:0] score2_q;
  logic [7:0] rally_q;
  logic       drop_flag_q;
  logic       game_over_q;
  logic       winner_q;
  logic       holder_q;
  logic       thrower_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] flight_cnt_q;
  logic [7:0] drop_cnt_q;

  logic       tick;
  logic       start_edge;
  logic       hold_expire;
  logic       flight_expire;
  logic       drop_expire;
  logic       score_evt;
  logic       scorer;
  logic [3:0] new_score;
  logic       win;

  always_comb begin
    tick          = vsync_q & ~bus.vsync;
    start_edge    = bus.start & ~start_q;
    hold_expire   = tick && ((hold_cnt_q + 8'd1) == HoldLast);
    flight_expire = tick && ((flight_cnt_q + 8'd1) == FlightLast);
    drop_expire   = tick && ((drop_cnt_q + 8'd1) == DropLast);
    score_evt     = 1'b0;
    scorer        = 1'b0;
    // A throw beats a coincident foul; a catch beats a coincident drop.
    if (state_q == StHold && !bus.throw_event && hold_expire) begin
      score_evt = 1'b1;
      scorer    = ~holder_q;
    end
    if (state_q == StFlight && !bus.catch_event &&
        (bus.ball_state == 2'b11 || flight_expire)) begin
      score_evt = 1'b1;
      scorer    = thrower_q;
    end
    new_score = scorer ? (score2_q + 4'd1) : (score1_q + 4'd1);
    win       = (new_score == WinScore);
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b1;
      start_q      <= 1'b0;
      serve_q      <= 1'b0;
      serve_to_q   <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      rally_q      <= 8'd0;
      drop_flag_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      holder_q     <= 1'b0;
      thrower_q    <= 1'b0;
      hold_cnt_q   <= 8'd0;
      flight_cnt_q <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      vsync_q <= bus.vsync;
      start_q <= bus.start;
      serve_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start_edge) begin
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            rally_q    <= 8'd0;
            serve_to_q <= 1'b0;
            serve_q    <= 1'b1;
            state_q    <= StServe;
          end
        end
        StServe: begin
          holder_q   <= serve_to_q;
          hold_cnt_q <= 8'd0;
          state_q    <= StHold;
        end
        StHold: begin
          if (bus.throw_event) begin
            thrower_q    <= holder_q;
            flight_cnt_q <= 8'd0;
            state_q      <= StFlight;
          end else if (tick && !score_evt) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        StFlight: begin
          if (bus.catch_event) begin
            if (bus.ball_state[0] != thrower_q && rally_q != 8'hff) begin
              rally_q <= rally_q + 8'd1;
            end
            holder_q   <= bus.ball_state[0];
            hold_cnt_q <= 8'd0;
            state_q    <= StHold;
          end else if (tick && !score_evt) begin
            flight_cnt_q <= flight_cnt_q + 8'd1;
          end
        end
        StDropped: begin
          if (drop_expire) begin
            drop_flag_q <= 1'b0;
            serve_q     <= 1'b1;
            state_q     <= StServe;
          end else if (tick) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
        end
        StOver: begin
          if (start_edge) begin
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            rally_q     <= 8'd0;
            serve_to_q  <= ~winner_q;
            game_over_q <= 1'b0;
            serve_q     <= 1'b1;
            state_q     <= StServe;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Scoring overrides the state-local next state chosen above.
      if (score_evt) begin
        if (scorer) begin
          score2_q <= new_score;
        end else begin
          score1_q <= new_score;
        end
        if (win) begin
          game_over_q <= 1'b1;
          winner_q    <= scorer;
          state_q     <= StOver;
        end else begin
          drop_flag_q <= 1'b1;
          rally_q     <= 8'd0;
          serve_to_q  <= ~scorer;
          drop_cnt_q  <= 8'd0;
          state_q     <= StDropped;
        end
      end
    end
  end

`ifdef CATCH_BEST_RALLY_EN
  logic [7:0] best_rally_q;

  always_ff @(posedge vclock) begin
    if (reset) begin
      best_rally_q <= 8'd0;
    end else if (rally_q > best_rally_q) begin
      best_rally_q <= rally_q;
    end
  end

  assign bus.best_rally = best_rally_q;
`else
  assign bus.best_rally = 8'd0;
`endif

  assign bus.serve       = serve_q;
  assign bus.serve_to    = serve_to_q;
  assign bus.round_state = state_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.rally       = rally_q;
  assign bus.drop_flag   = drop_flag_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_catch_round_ctrl.sv
// Directed bench for catch_round_ctrl: serve, rally, drop, foul, tie-breaks, game over, restart.
module tb_catch_round_ctrl;

  logic vclock;
  logic reset;
  int   n_cmp;
  int   n_err;

  catch_round_ctrl_if bus ();

  catch_round_ctrl dut (
    .vclock (vclock),
    .reset  (reset),
    .bus    (bus)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

`ifdef CATCH_BEST_RALLY_EN
  localparam logic [7:0] BestAfterFirstGame = 8'd4;
  localparam logic [7:0] BestAfterFive      = 8'd5;
`else
  localparam logic [7:0] BestAfterFirstGame = 8'd0;
  localparam logic [7:0] BestAfterFive      = 8'd0;
`endif

  task automatic step();
    @(posedge vclock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick1();
    bus.vsync = 1'b0;
    step();
    bus.vsync = 1'b1;
    step();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick1();
  endtask

  task automatic do_throw();
    bus.throw_event = 1'b1;
    bus.ball_state  = 2'b10;
    step();
    bus.throw_event = 1'b0;
  endtask

  task automatic do_catch(input logic c);
    bus.ball_state  = {1'b0, c};
    bus.catch_event = 1'b1;
    step();
    bus.catch_event = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.vsync = 1'b1;
    bus.start = 1'b0;
    bus.ball_state = 2'b11;
    bus.catch_event = 1'b0;
    bus.throw_event = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_state", 32'(bus.round_state), 0);
    chk("rst_serve", 32'(bus.serve), 0);
    chk("rst_score1", 32'(bus.score1), 0);
    chk("rst_score2", 32'(bus.score2), 0);
    chk("rst_rally", 32'(bus.rally), 0);
    chk("rst_drop", 32'(bus.drop_flag), 0);
    chk("rst_over", 32'(bus.game_over), 0);
    chk("rst_best", 32'(bus.best_rally), 0);

    // Start edge -> one-cycle serve to glove1, then HOLD
    bus.start = 1'b1;
    step();
    chk("start_serve", 32'(bus.serve), 1);
    chk("start_serve_to", 32'(bus.serve_to), 0);
    chk("start_state_serve", 32'(bus.round_state), 1);
    step();
    chk("serve_one_cycle", 32'(bus.serve), 0);
    chk("state_hold", 32'(bus.round_state), 2);
    bus.start = 1'b0;
    bus.ball_state = 2'b00;

    // Three alternating passes: catchers 1,0,1
    do_throw();
    chk("throw_flight", 32'(bus.round_state), 3);
    do_catch(1'b1);
    chk("catch_hold", 32'(bus.round_state), 2);
    do_throw();
    do_catch(1'b0);
    do_throw();
    do_catch(1'b1);
    chk("rally3", 32'(bus.rally), 3);
    chk("rally3_s1", 32'(bus.score1), 0);
    chk("rally3_s2", 32'(bus.score2), 0);
    do_throw();
    do_catch(1'b1);
    chk("self_catch", 32'(bus.rally), 3);

    // Start edge in HOLD is ignored
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_ignored_state", 32'(bus.round_state), 2);
    chk("start_ignored_serve", 32'(bus.serve), 0);

    // Back to holder 0, then player 1 throws and the ball is lost
    do_throw();
    do_catch(1'b0);
    chk("rally4", 32'(bus.rally), 4);
    do_throw();
    bus.ball_state = 2'b11;
    step();
    chk("drop_state", 32'(bus.round_state), 4);
    chk("drop_score1", 32'(bus.score1), 1);
    chk("drop_flag", 32'(bus.drop_flag), 1);
    chk("drop_rally0", 32'(bus.rally), 0);
    chk("drop_serve_to", 32'(bus.serve_to), 1);
    wait_ticks(89);
    chk("drop89_state", 32'(bus.round_state), 4);
    chk("drop89_serve", 32'(bus.serve), 0);
    bus.vsync = 1'b0;
    step();
    chk("drop90_serve", 32'(bus.serve), 1);
    chk("drop90_serve_to", 32'(bus.serve_to), 1);
    chk("drop90_flag", 32'(bus.drop_flag), 0);
    bus.vsync = 1'b1;
    step();
    chk("drop90_hold", 32'(bus.round_state), 2);
    bus.ball_state = 2'b01;

    // Holder 1 fouls after 180 ticks: player 1 scores
    wait_ticks(179);
    chk("hold179_state", 32'(bus.round_state), 2);
    tick1();
    chk("foul_state", 32'(bus.round_state), 4);
    chk("foul_score1", 32'(bus.score1), 2);
    chk("foul_score2", 32'(bus.score2), 0);
    chk("foul_serve_to", 32'(bus.serve_to), 1);
    wait_ticks(90);
    chk("foul_reserve", 32'(bus.round_state), 2);

    // Throw on the 180th tick wins over the foul
    wait_ticks(179);
    bus.vsync = 1'b0;
    bus.throw_event = 1'b1;
    bus.ball_state = 2'b10;
    step();
    bus.vsync = 1'b1;
    bus.throw_event = 1'b0;
    chk("throw_vs_foul_state", 32'(bus.round_state), 3);
    chk("throw_vs_foul_s1", 32'(bus.score1), 2);
    step();

    // Catch on the flight-timeout tick wins over the drop
    wait_ticks(239);
    chk("flight239_state", 32'(bus.round_state), 3);
    bus.vsync = 1'b0;
    bus.catch_event = 1'b1;
    bus.ball_state = 2'b00;
    step();
    bus.vsync = 1'b1;
    bus.catch_event = 1'b0;
    chk("catch_vs_timeout_state", 32'(bus.round_state), 2);
    chk("catch_vs_timeout_s1", 32'(bus.score1), 2);
    chk("catch_vs_timeout_s2", 32'(bus.score2), 0);
    chk("catch_vs_timeout_rally", 32'(bus.rally), 1);
    step();

    // Player 2 scores seven times by drops
    for (int k = 1; k <= 7; k++) begin
      do_throw();
      do_catch(1'b1);
      do_throw();
      bus.ball_state = 2'b11;
      step();
      chk("p2_score", 32'(bus.score2), 32'(k));
      if (k < 7) begin
        chk("p2_serve_to", 32'(bus.serve_to), 0);
        wait_ticks(90);
        bus.ball_state = 2'b00;
      end
    end
    chk("over_state", 32'(bus.round_state), 5);
    chk("over_flag", 32'(bus.game_over), 1);
    chk("over_winner", 32'(bus.winner), 1);
    chk("over_drop_flag", 32'(bus.drop_flag), 0);

    // Events in OVER are ignored
    bus.throw_event = 1'b1;
    bus.catch_event = 1'b1;
    step();
    bus.throw_event = 1'b0;
    bus.catch_event = 1'b0;
    wait_ticks(200);
    chk("over_hold_state", 32'(bus.round_state), 5);
    chk("over_hold_s1", 32'(bus.score1), 2);
    chk("over_hold_s2", 32'(bus.score2), 7);
    chk("over_hold_winner", 32'(bus.winner), 1);
    chk("over_hold_flag", 32'(bus.game_over), 1);

    // New game: serve to the loser (player 1)
    bus.start = 1'b1;
    step();
    chk("restart_serve", 32'(bus.serve), 1);
    chk("restart_serve_to", 32'(bus.serve_to), 0);
    chk("restart_s1", 32'(bus.score1), 0);
    chk("restart_s2", 32'(bus.score2), 0);
    chk("restart_rally", 32'(bus.rally), 0);
    chk("restart_over", 32'(bus.game_over), 0);
    chk("best_persist", 32'(bus.best_rally), 32'(BestAfterFirstGame));
    bus.start = 1'b0;
    step();
    chk("restart_hold", 32'(bus.round_state), 2);

    // Rally of five, then a drop
    bus.ball_state = 2'b00;
    do_throw();
    do_catch(1'b1);
    do_throw();
    do_catch(1'b0);
    do_throw();
    do_catch(1'b1);
    do_throw();
    do_catch(1'b0);
    do_throw();
    do_catch(1'b1);
    chk("rally5", 32'(bus.rally), 5);
    do_throw();
    bus.ball_state = 2'b11;
    step();
    chk("rally5_drop_s2", 32'(bus.score2), 1);
    chk("rally5_drop_rally", 32'(bus.rally), 0);
    step();
    chk("best_rally5", 32'(bus.best_rally), 32'(BestAfterFive));

    // Reset mid-game aborts to IDLE with no serve
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("abort_state", 32'(bus.round_state), 0);
    chk("abort_serve", 32'(bus.serve), 0);
    chk("abort_best", 32'(bus.best_rally), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
